// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the 8-bit combinational ALU, with a registered, back-pressured result.
// Optional build macro ALU_CMD_QUEUE_FLAGS_EN adds registered out_zero/out_neg result flags.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic [2:0]    in_func,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_func,
    input  logic [7:0]    alu_c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_c,
    output logic [2:0]    out_func,
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    output logic          out_zero,
    output logic          out_neg,
`endif
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [7:0]    mem_a_q    [DEPTH];
    logic [7:0]    mem_b_q    [DEPTH];
    logic [2:0]    mem_func_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    out_c_q;
    logic [2:0]    out_func_q;
    logic          push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q < FULL_COUNT);
    assign push      = in_valid && in_ready;

    // Idle drive of func=111 makes the ALU return 0 while the queue is empty.
    assign alu_a    = not_empty ? mem_a_q[rd_ptr_q]    : 8'h00;
    assign alu_b    = not_empty ? mem_b_q[rd_ptr_q]    : 8'h00;
    assign alu_func = not_empty ? mem_func_q[rd_ptr_q] : 3'b111;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]    <= in_a;
            mem_b_q[wr_ptr_q]    <= in_b;
            mem_func_q[wr_ptr_q] <= in_func;
        end
    end

    // A pop is always a capture: the head leaves the queue exactly when its result is registered.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (not_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            out_c_q    <= 8'h00;
            out_func_q <= 3'b000;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                out_c_q    <= alu_c;
                out_func_q <= mem_func_q[rd_ptr_q];
            end
            count_q <= count_d;
            state_q <= state_d;
        end
    end

`ifdef ALU_CMD_QUEUE_FLAGS_EN
    logic out_zero_q, out_neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
        end else if (pop) begin
            out_zero_q <= (alu_c == 8'h00);
            out_neg_q  <= alu_c[7];
        end
    end

    assign out_zero = out_zero_q;
    assign out_neg  = out_neg_q;
`endif

    assign out_valid = (state_q == HOLD);
    assign out_c     = out_c_q;
    assign out_func  = out_func_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomised bench for alu_cmd_queue: a behavioural ALU drives alu_c, and a queue-based
// reference model predicts handshakes, occupancy and results cycle by cycle.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a, in_b;
    logic [2:0]    in_func;
    logic [7:0]    alu_a, alu_b, alu_c;
    logic [2:0]    alu_func;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_c;
    logic [2:0]    out_func;
    logic [CW-1:0] count;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
    logic          out_zero, out_neg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_func   (in_func),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_func  (alu_func),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_func  (out_func),
`ifdef ALU_CMD_QUEUE_FLAGS_EN
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    // Combinational ALU standing in for the real one downstream of the queue.
    function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a ^ b;
            3'b100:  return ~a;
            3'b101:  return {a[6:0], 1'b0};
            3'b110:  return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_c = alu_ref(alu_func, alu_a, alu_b);

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t       mq[$];
    logic       m_valid;
    logic [7:0] m_c;
    logic [2:0] m_func;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model update for one rising edge, using the inputs held across that edge.
    task automatic model_edge();
        cmd_t c;
        bit   do_push;
        do_push = in_valid && (mq.size() < DEPTH);
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_c     = 8'h00;
            m_func  = 3'b000;
        end else begin
            if (mq.size() > 0 && (!m_valid || out_ready)) begin
                c       = mq.pop_front();
                m_valid = 1'b1;
                m_c     = alu_ref(c.f, c.a, c.b);
                m_func  = c.f;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) mq.push_back('{f: in_func, a: in_a, b: in_b});
        end
    endtask

    task automatic compare_all();
        logic [7:0] zc;
        check("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        check("count",     32'(count),     32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_c",     32'(out_c),     32'(m_c));
        check("out_func",  32'(out_func),  32'(m_func));
        if (mq.size() > 0) begin
            check("alu_a",    32'(alu_a),    32'(mq[0].a));
            check("alu_b",    32'(alu_b),    32'(mq[0].b));
            check("alu_func", 32'(alu_func), 32'(mq[0].f));
        end else begin
            check("alu_a_idle",    32'(alu_a),    32'(0));
            check("alu_b_idle",    32'(alu_b),    32'(0));
            check("alu_func_idle", 32'(alu_func), 32'(7));
        end
`ifdef ALU_CMD_QUEUE_FLAGS_EN
        zc = m_c;
        check("out_zero", 32'(out_zero), 32'(m_valid ? (zc == 8'h00) : (zc == 8'h00 && !rst_seen_since_capture())));
        check("out_neg",  32'(out_neg),  32'(zc[7]));
`endif
    endtask

`ifdef ALU_CMD_QUEUE_FLAGS_EN
    // After reset the flags are 0 even though out_c=0; track whether a capture happened since.
    bit captured_since_rst = 1'b0;
    function automatic bit rst_seen_since_capture();
        return !captured_since_rst;
    endfunction
`endif

    task automatic cycle();
        @(posedge clk);
`ifdef ALU_CMD_QUEUE_FLAGS_EN
        if (rst) captured_since_rst = 1'b0;
        else if (mq.size() > 0 && (!m_valid || out_ready)) captured_since_rst = 1'b1;
`endif
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_func  = f;
        in_a     = a;
        in_b     = b;
        cycle();
    endtask

    task automatic random_phase(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            drive(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_func = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_c = 8'h00; m_func = 3'b000;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_count",    32'(count),     32'(0));
        check("rst_valid",    32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready),  32'(1));
        rst = 1'b0;

        // Single add through an empty queue: visible two edges after the push.
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'h05, 8'h03);
        check("lat_n1_valid", 32'(out_valid), 32'(0));
        check("lat_n1_count", 32'(count),     32'(1));
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("add_valid", 32'(out_valid), 32'(1));
        check("add_c",     32'(out_c),     32'(8'h08));
        check("add_count", 32'(count),     32'(0));
        drive(1'b0, 3'b000, 8'h00, 8'h00);

        drive(1'b1, 3'b001, 8'h02, 8'h05);
        drive(1'b1, 3'b101, 8'h81, 8'h01);
        check("sub_wrap_c", 32'(out_c), 32'(8'hFD));
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("shl_c",    32'(out_c),    32'(8'h02));
        check("shl_func", 32'(out_func), 32'(3'b101));
        drive(1'b0, 3'b000, 8'h00, 8'h00);

        // Backpressure: five pushes fill the queue behind a held result.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 3'b000, 8'(8'h10 + i), 8'h01);
        check("full_count",    32'(count),    32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("held_c",        32'(out_c),    32'(8'h11));
        drive(1'b1, 3'b111, 8'h55, 8'h55);
        drive(1'b1, 3'b111, 8'h55, 8'h55);
        check("held_c2", 32'(out_c), 32'(8'h11));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("drain_count", 32'(count), 32'(0));

        // Concurrent push/pop with pointer wrap.
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 8'hF0, 8'h3C);
        drive(1'b1, 3'b011, 8'h0F, 8'hFF);
        drive(1'b1, 3'b110, 8'h80, 8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
        check("steady_count", 32'(count), 32'(2));

        random_phase(300, 60);

        // Reset in the middle of traffic.
        out_ready = 1'b0;
        rst = 1'b1; drive(1'b0, 3'b000, 8'h00, 8'h00); rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b000, 8'(i + 1), 8'h20);
        check("pre_rst_count", 32'(count),     32'(3));
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        rst = 1'b0;
        check("mid_rst_count",    32'(count),     32'(0));
        check("mid_rst_valid",    32'(out_valid), 32'(0));
        check("mid_rst_c",        32'(out_c),     32'(0));
        check("mid_rst_in_ready", 32'(in_ready),  32'(1));
        check("mid_rst_alu_func", 32'(alu_func),  32'(7));

`ifdef ALU_CMD_QUEUE_FLAGS_EN
        out_ready = 1'b1;
        drive(1'b1, 3'b011, 8'hAA, 8'hAA);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("xor_zero_c", 32'(out_c),    32'(8'h00));
        check("xor_zero_z", 32'(out_zero), 32'(1));
        check("xor_zero_n", 32'(out_neg),  32'(0));
        drive(1'b1, 3'b100, 8'h00, 8'h12);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("not_c", 32'(out_c),    32'(8'hFF));
        check("not_z", 32'(out_zero), 32'(0));
        check("not_n", 32'(out_neg),  32'(1));
`endif

        random_phase(400, 50);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("final_count", 32'(count),     32'(0));
        check("final_valid", 32'(out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
